// File: rtl/pipe_ifu.sv
// Instruction-fetch unit: drives the req/ack imem port, the IF/ID register and the
// redirect flush. Optional counters are enabled with `define PIPE_IFU_PERF_EN.
module pipe_ifu #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [INST_W-1:0]  NOP      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IFwip,
  input  logic              IDwir,
  input  logic              IFwillJump,
  input  logic [ADDR_W-1:0] MEMtarget,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] IDinst,
  output logic [ADDR_W-1:0] IDpc4,
  output logic              IDvalid,
  output logic              EXflush
`ifdef PIPE_IFU_PERF_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_redir,
  output logic [31:0]       perf_fetch
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_plus4_s;
  logic [ADDR_W-1:0] target_s;
  logic [INST_W-1:0] hold_inst_r;
  logic [ADDR_W-1:0] hold_pc4_r;
  logic              hold_v_r;
  logic [INST_W-1:0] id_inst_r;
  logic [ADDR_W-1:0] id_pc4_r;
  logic              id_valid_r;
  logic              issue_s;
  logic              accept_s;

  assign pc_plus4_s = pc_r + ADDR_W'(4);
  assign target_s   = {MEMtarget[ADDR_W-1:2], 2'b00};

  // Request qualification: an outstanding request is held until its ack arrives.
  always_comb begin
    issue_s = 1'b0;
    case (state_r)
      ST_IDLE: issue_s = IFwip & ~hold_v_r & ~IFwillJump;
      ST_REQ:  issue_s = 1'b1;
      ST_DROP: issue_s = 1'b1;
      default: issue_s = 1'b0;
    endcase
  end

  // Data is kept only for live requests; a redirect or a DROP response discards it.
  assign accept_s = issue_s & imem_ack & ~IFwillJump & (state_r != ST_DROP);

  // Fetch state transitions.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (issue_s && !imem_ack) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          state_nxt_s = ST_IDLE;
        end else if (IFwillJump) begin
          state_nxt_s = ST_DROP;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DROP: begin
        // An ack here retires the abandoned request even if another redirect arrives.
        if (imem_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // PC, hold buffer and IF/ID register; redirect takes priority over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_PC;
      hold_inst_r <= NOP;
      hold_pc4_r  <= {ADDR_W{1'b0}};
      hold_v_r    <= 1'b0;
      id_inst_r   <= NOP;
      id_pc4_r    <= {ADDR_W{1'b0}};
      id_valid_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (IFwillJump) begin
        pc_r       <= target_s;
        id_inst_r  <= NOP;
        id_valid_r <= 1'b0;
        hold_v_r   <= 1'b0;
      end else if (accept_s) begin
        pc_r <= pc_plus4_s;
        if (IDwir && !hold_v_r) begin
          id_inst_r  <= imem_rdata;
          id_pc4_r   <= pc_plus4_s;
          id_valid_r <= 1'b1;
        end else begin
          hold_inst_r <= imem_rdata;
          hold_pc4_r  <= pc_plus4_s;
          hold_v_r    <= 1'b1;
        end
      end else if (IDwir && hold_v_r) begin
        id_inst_r  <= hold_inst_r;
        id_pc4_r   <= hold_pc4_r;
        id_valid_r <= 1'b1;
        hold_v_r   <= 1'b0;
      end else if (IDwir) begin
        id_inst_r  <= NOP;
        id_valid_r <= 1'b0;
      end else begin
        id_inst_r  <= id_inst_r;
        id_valid_r <= id_valid_r;
      end
    end
  end

  // Reset gates the combinational outputs so nothing escapes while rst_n is low.
  assign imem_req  = rst_n & issue_s;
  assign imem_addr = pc_r;
  assign EXflush   = rst_n & IFwillJump;
  assign IDinst    = id_inst_r;
  assign IDpc4     = id_pc4_r;
  assign IDvalid   = id_valid_r;

`ifdef PIPE_IFU_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_stall_r;
  logic [31:0] perf_redir_r;
  logic [31:0] perf_fetch_r;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_r <= 32'd0;
      perf_redir_r <= 32'd0;
      perf_fetch_r <= 32'd0;
    end else begin
      if (!IFwip || !IDwir) begin
        perf_stall_r <= sat_inc(perf_stall_r);
      end
      if (IFwillJump) begin
        perf_redir_r <= sat_inc(perf_redir_r);
      end
      if (accept_s) begin
        perf_fetch_r <= sat_inc(perf_fetch_r);
      end
    end
  end

  assign perf_stall = perf_stall_r;
  assign perf_redir = perf_redir_r;
  assign perf_fetch = perf_fetch_r;
`endif

endmodule

// File: tb/tb_pipe_ifu.sv
// Self-checking bench for pipe_ifu: directed scenarios with constant expectations
// plus a randomized run against a queue-free behavioural fetch model.
module tb_pipe_ifu;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IFwip, IDwir, IFwillJump;
  logic [31:0] MEMtarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IDinst;
  logic [31:0] IDpc4;
  logic        IDvalid;
  logic        EXflush;
`ifdef PIPE_IFU_PERF_EN
  logic [31:0] perf_stall, perf_redir, perf_fetch;
`endif

  pipe_ifu dut (
    .clk(clk), .rst_n(rst_n), .IFwip(IFwip), .IDwir(IDwir), .IFwillJump(IFwillJump),
    .MEMtarget(MEMtarget), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .IDinst(IDinst), .IDpc4(IDpc4), .IDvalid(IDvalid), .EXflush(EXflush)
`ifdef PIPE_IFU_PERF_EN
    , .perf_stall(perf_stall), .perf_redir(perf_redir), .perf_fetch(perf_fetch)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  int lat      = 0;
  int wcnt     = 0;

  // Behavioural model: what the fetch unit should hold, in architectural terms.
  logic [31:0] m_pc, m_inst, m_pc4, m_hinst, m_hpc4;
  logic        m_valid, m_hv, m_out, m_disc;
  logic        exp_req, exp_flush;
  logic [31:0] exp_addr;
  logic        obs_req, obs_flush, obs_valid;
  logic [31:0] obs_addr, obs_inst, obs_pc4;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_inst = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
    m_hv = 1'b0; m_hinst = NOP; m_hpc4 = 32'h0; m_out = 1'b0; m_disc = 1'b0;
    wcnt = 0;
  endtask

  task automatic model_step(input logic wip, input logic wir, input logic jmp,
                            input logic [31:0] tgt, input logic ack, input logic [31:0] rd);
    logic issued;
    logic take;
    issued = m_out || (wip && !m_hv && !jmp);
    take   = issued && ack && !m_disc && !jmp;
    if (jmp) begin
      m_pc = tgt & 32'hFFFF_FFFC; m_inst = NOP; m_valid = 1'b0; m_hv = 1'b0;
    end else if (take) begin
      if (wir && !m_hv) begin
        m_inst = rd; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end else begin
        m_hinst = rd; m_hpc4 = m_pc + 32'd4; m_hv = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (wir && m_hv) begin
      m_inst = m_hinst; m_pc4 = m_hpc4; m_valid = 1'b1; m_hv = 1'b0;
    end else if (wir) begin
      m_inst = NOP; m_valid = 1'b0;
    end
    m_disc = issued && !ack && (m_disc || jmp);
    m_out  = issued && !ack;
  endtask

  // One clock: drive at the falling edge, respond as memory, capture after the rising edge.
  task automatic tick(input logic wip, input logic wir, input logic jmp, input logic [31:0] tgt);
    logic        ack;
    logic [31:0] rd;
    IFwip = wip; IDwir = wir; IFwillJump = jmp; MEMtarget = tgt;
    #1;
    exp_req   = m_out || (wip && !m_hv && !jmp);
    exp_addr  = m_pc;
    exp_flush = jmp;
    ack = imem_req && (wcnt >= lat);
    rd  = ack ? inst_of(imem_addr) : 32'hDEAD_BEEF;
    imem_ack = ack; imem_rdata = rd;
    #1;
    obs_req = imem_req; obs_addr = imem_addr; obs_flush = EXflush;
    wcnt = (imem_req && !ack) ? wcnt + 1 : 0;
    model_step(wip, wir, jmp, tgt, ack, rd);
    @(posedge clk);
    #1;
    obs_inst = IDinst; obs_pc4 = IDpc4; obs_valid = IDvalid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; IFwip = 1'b1; IDwir = 1'b1; IFwillJump = 1'b1; MEMtarget = 32'h40;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b want=0", imem_req); else pass_cnt++;
    total++; if (EXflush !== 1'b0) $display("FAIL reset_flush got=%b want=0", EXflush); else pass_cnt++;
    total++; if (IDvalid !== 1'b0) $display("FAIL reset_valid got=%b want=0", IDvalid); else pass_cnt++;
    total++; if (IDinst !== NOP) $display("FAIL reset_inst got=%h want=%h", IDinst, NOP); else pass_cnt++;
    total++; if (IDpc4 !== 32'h0) $display("FAIL reset_pc4 got=%h want=0", IDpc4); else pass_cnt++;
    total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got=%h want=0", imem_addr); else pass_cnt++;
    IFwillJump = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i) * 32'd4;
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      total++; if (obs_req !== 1'b1 || obs_addr !== a) $display("FAIL zw_addr[%0d] got=%b/%h want=1/%h", i, obs_req, obs_addr, a); else pass_cnt++;
      total++; if (obs_pc4 !== a + 32'd4 || obs_valid !== 1'b1) $display("FAIL zw_pc4[%0d] got=%h/%b want=%h/1", i, obs_pc4, obs_valid, a + 32'd4); else pass_cnt++;
      total++; if (obs_inst !== inst_of(a)) $display("FAIL zw_inst[%0d] got=%h want=%h", i, obs_inst, inst_of(a)); else pass_cnt++;
    end
  endtask

  task automatic test_wait_latency();
    lat = 2;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      total++; if (obs_req !== 1'b1 || obs_addr !== 32'h10) $display("FAIL wait_req[%0d] got=%b/%h want=1/10", k, obs_req, obs_addr); else pass_cnt++;
      if (k < 2) begin
        total++; if (obs_valid !== 1'b0 || obs_inst !== NOP) $display("FAIL wait_idle[%0d] got=%b/%h want=0/%h", k, obs_valid, obs_inst, NOP); else pass_cnt++;
      end else begin
        total++; if (obs_valid !== 1'b1 || obs_pc4 !== 32'h14 || obs_inst !== inst_of(32'h10)) $display("FAIL wait_ack got=%b/%h/%h want=1/14/%h", obs_valid, obs_pc4, obs_inst, inst_of(32'h10)); else pass_cnt++;
      end
    end
  endtask

  task automatic test_hold();
    lat = 0;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'h14) $display("FAIL hold_fetch got=%b/%h want=1/14", obs_req, obs_addr); else pass_cnt++;
    total++; if (obs_pc4 !== 32'h14 || obs_valid !== 1'b1) $display("FAIL hold_frozen got=%h/%b want=14/1", obs_pc4, obs_valid); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      total++; if (obs_req !== 1'b0 || obs_pc4 !== 32'h14) $display("FAIL hold_stall[%0d] got=%b/%h want=0/14", k, obs_req, obs_pc4); else pass_cnt++;
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (obs_req !== 1'b0) $display("FAIL hold_drain_req got=%b want=0", obs_req); else pass_cnt++;
    total++; if (obs_pc4 !== 32'h18 || obs_inst !== inst_of(32'h14)) $display("FAIL hold_drain got=%h/%h want=18/%h", obs_pc4, obs_inst, inst_of(32'h14)); else pass_cnt++;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (obs_addr !== 32'h18 || obs_pc4 !== 32'h1C) $display("FAIL hold_resume got=%h/%h want=18/1c", obs_addr, obs_pc4); else pass_cnt++;
  endtask

  task automatic test_redirect();
    lat = 100;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, 32'h100);
    total++; if (obs_flush !== 1'b1) $display("FAIL redir_flush got=%b want=1", obs_flush); else pass_cnt++;
    total++; if (obs_valid !== 1'b0 || obs_req !== 1'b1) $display("FAIL redir_drop got=%b/%b want=0/1", obs_valid, obs_req); else pass_cnt++;
    lat = 0;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (obs_flush !== 1'b0 || obs_valid !== 1'b0) $display("FAIL redir_discard got=%b/%b want=0/0", obs_flush, obs_valid); else pass_cnt++;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (obs_addr !== 32'h100 || obs_pc4 !== 32'h104 || obs_valid !== 1'b1) $display("FAIL redir_target got=%h/%h/%b want=100/104/1", obs_addr, obs_pc4, obs_valid); else pass_cnt++;
    total++; if (obs_inst !== inst_of(32'h100)) $display("FAIL redir_inst got=%h want=%h", obs_inst, inst_of(32'h100)); else pass_cnt++;
  endtask

  task automatic test_jump_hold();
    lat = 0;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b1, 32'h203);
    total++; if (obs_req !== 1'b0 || obs_flush !== 1'b1) $display("FAIL jh_flush got=%b/%b want=0/1", obs_req, obs_flush); else pass_cnt++;
    total++; if (obs_inst !== NOP || obs_valid !== 1'b0) $display("FAIL jh_nop got=%h/%b want=%h/0", obs_inst, obs_valid, NOP); else pass_cnt++;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'h200 || obs_pc4 !== 32'h204) $display("FAIL jh_target got=%b/%h/%h want=1/200/204", obs_req, obs_addr, obs_pc4); else pass_cnt++;
  endtask

  task automatic test_wrap();
    lat = 0;
    tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (obs_addr !== 32'hFFFF_FFFC || obs_pc4 !== 32'h0) $display("FAIL wrap_edge got=%h/%h want=fffffffc/0", obs_addr, obs_pc4); else pass_cnt++;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (obs_addr !== 32'h0 || obs_pc4 !== 32'h4) $display("FAIL wrap_next got=%h/%h want=0/4", obs_addr, obs_pc4); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    lat = 100;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || IDvalid !== 1'b0) $display("FAIL rstmid got=%b/%b want=0/0", imem_req, IDvalid); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    lat = 0;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (obs_addr !== 32'h0 || obs_pc4 !== 32'h4) $display("FAIL rstmid_restart got=%h/%h want=0/4", obs_addr, obs_pc4); else pass_cnt++;
  endtask

  task automatic test_random();
    int          errs;
    logic        wip, wir, jmp;
    logic [31:0] tgt;
    errs = 0;
    for (int n = 0; n < 600; n++) begin
      if (wcnt == 0) lat = $urandom_range(0, 2);
      wip = ($urandom_range(0, 9) < 8);
      wir = ($urandom_range(0, 3) != 0);
      jmp = ($urandom_range(0, 11) == 0);
      tgt = {16'h0, 16'($urandom)};
      tick(wip, wir, jmp, tgt);
      total++;
      if (obs_req !== exp_req || obs_addr !== exp_addr || obs_flush !== exp_flush ||
          obs_inst !== m_inst || obs_pc4 !== m_pc4 || obs_valid !== m_valid) begin
        errs++;
        if (errs <= 10)
          $display("FAIL rand[%0d] got req=%b addr=%h fl=%b inst=%h pc4=%h v=%b want req=%b addr=%h fl=%b inst=%h pc4=%h v=%b",
                   n, obs_req, obs_addr, obs_flush, obs_inst, obs_pc4, obs_valid,
                   exp_req, exp_addr, exp_flush, m_inst, m_pc4, m_valid);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_latency();
    test_hold();
    test_redirect();
    test_jump_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
